snake_dir_ctrl: RTL

// - Upstream control stage for the snake draw/erase FSM: turns raw KEY[3:0] presses into a committed

---
 rtl/snake_pkg.sv | 12 +
 rtl/key_debounce.sv | 29 ++
 rtl/snake_dir_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding and control-FSM states shared by the snake control and draw FSMs
package snake_pkg;
  localparam int DIR_W = 2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN = 2'd1;
  localparam logic [DIR_W-1:0] DIR_UP = 2'd2;
  localparam logic [DIR_W-1:0] DIR_LEFT = 2'd3;
  typedef enum logic {ST_IDLE, ST_REQ} ctrl_state_t;
  function automatic logic is_reverse(input logic [DIR_W-1:0] a, input logic [DIR_W-1:0] b);
    return ({1'b0, a} + {1'b0, b}) == 3'd3;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and press-edge pulse for one active-low key
module key_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES) > 0 ? $clog2(DB_CYCLES) : 1;
  logic s1, s2, level, done;
  logic [CW-1:0] cnt;
  assign done = (s2 != level) && (cnt == CW'(DB_CYCLES - 1));
  // synchronize, count stable mismatch cycles, flip level and flag a 1->0 flip as a press
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      cnt <= (s2 == level || done) ? '0 : cnt + CW'(1);
      level <= done ? s2 : level;
      press <= done & ~s2;
    end
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: key presses -> committed direction plus paced step requests; SNAKE_NO_REVERSE_EN drops reversals
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int TICK_W = 20,
  parameter logic [DIR_W-1:0] INIT_DIR = DIR_RIGHT
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [3:0]       key_n,
  input  logic             run,
  input  logic             step_ack,
  output logic [DIR_W-1:0] dir,
  output logic             step_req,
  output logic             overrun
);
  logic [3:0] press;
  logic [DIR_W-1:0] sel, pend_dir, dir_nx;
  logic accept, tick, ovr_nx;
  logic [TICK_W-1:0] tcnt;
  ctrl_state_t state, state_nx;
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLOCK_50(CLOCK_50),
      .resetn(resetn),
      .key_n(key_n[g]),
      .press(press[g])
    );
  end
  assign sel = press[0] ? DIR_RIGHT : press[1] ? DIR_DOWN : press[2] ? DIR_UP : DIR_LEFT;
`ifdef SNAKE_NO_REVERSE_EN
  assign accept = |press && !is_reverse(sel, dir);
`else
  assign accept = |press;
`endif
  assign tick = run & (&tcnt);
  assign step_req = state == ST_REQ;
  // latest accepted press waits here until the next step is issued
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) pend_dir <= INIT_DIR;
    else if (accept) pend_dir <= sel;
  // free-running step pacing counter, frozen while paused
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) tcnt <= '0;
    else tcnt <= tcnt + TICK_W'(run);
  // request FSM state and the outputs it owns
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= ST_IDLE;
      dir <= INIT_DIR;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
      overrun <= ovr_nx;
    end
  // tick issues a step from IDLE; ack retires it; a tick while pending is dropped and flagged
  always_comb begin
    state_nx = (state == ST_IDLE) ? (tick ? ST_REQ : ST_IDLE) : (step_ack ? ST_IDLE : ST_REQ);
    dir_nx = (state == ST_IDLE && tick) ? pend_dir : dir;
    ovr_nx = overrun | (state == ST_REQ && tick);
  end
endmodule
